// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the mesh traffic injector.
// Holds the 26-bit packet word field offsets, the injector FSM state
// encodings and the destination-valid check used by the generator and the top.
package noc_pkg;

  // Packet word field offsets. Bit 25 is always 0. Bits [2:0] repeat PacketID[2:0] as check bits.
  localparam int PID_MSB = 24;
  localparam int PID_LSB = 15;
  localparam int SID_MSB = 14;
  localparam int SID_LSB = 9;
  localparam int DST_MSB = 8;
  localparam int DST_LSB = 3;

  // Injector FSM encodings. These are kept as plain constants so older code can compare against them.
  localparam logic [0:0] GAP = 1'b0;
  localparam logic [0:0] REQ = 1'b1;

  // A destination is usable when it lies inside the mesh and is not this node.
  function automatic logic destValid(input logic [5:0] dest,
                                     input logic [5:0] self,
                                     input int         meshSize);
    logic xOk;
    logic yOk;
    xOk = int'(dest[5:3]) < meshSize;
    yOk = int'(dest[2:0]) < meshSize;
    return xOk && yOk && (dest != self);
  endfunction

endpackage

// File: rtl/packet_injector_if.sv
// packet_injector_if: Req/Gnt/Full handshake between a traffic source and the
// router's local input port. The master side drives the packet and the request.
// The slave side, which is the router, returns the grant pulse and the buffer-full flag.
interface packet_injector_if #(
  parameter int packetwidth = 26
);
  logic [packetwidth-1:0] PacketOut;
  logic                   ReqDnStr;
  logic                   GntDnStr;
  logic                   DnStrFull;

  modport master (output PacketOut, output ReqDnStr, input GntDnStr, input DnStrFull);
  modport slave  (input PacketOut, input ReqDnStr, output GntDnStr, output DnStrFull);
endinterface

// File: rtl/packet_injector_dest_gen.sv
// dest_gen: destination generator for the packet injector.
// Default build: a round-robin scan over the mesh. The scan runs with y as the
// minor coordinate and skips this node.
// With INJ_LFSR_EN defined: a 6-bit Fibonacci LFSR (x^6+x^5+1) that free-runs
// while the injector waits. Any invalid candidate is simply retried on the next cycle.
// hold is high while a request is outstanding. step (the router grant) is only
// honoured while holding, so that a grant that arrives out of turn never moves the generator.
module dest_gen
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID  = 6'b001_010,
  parameter int         MESH_SIZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       hold,
  output logic [5:0] dest,
  output logic       valid
);

  logic accept;
  assign accept = step && hold;

`ifdef INJ_LFSR_EN

  logic [5:0] lfsr;

  // The LFSR steps every cycle while waiting. It freezes under a pending request and steps once more when that request is granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= 6'b000001;
    end else if (!hold || accept) begin
      lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    end
  end

  assign dest = lfsr;

`else

  localparam logic [2:0] LAST  = 3'(MESH_SIZE - 1);
  localparam logic [5:0] START = (routerID == 6'd0) ? 6'b000_001 : 6'b000_000;

  logic [5:0] cur;
  logic [5:0] nxt1;
  logic [5:0] nxt2;

  function automatic logic [5:0] rrNext(input logic [5:0] p);
    logic [2:0] x;
    logic [2:0] y;
    x = p[5:3];
    y = p[2:0];
    if (y == LAST) begin
      y = 3'd0;
      x = (x == LAST) ? 3'd0 : x + 3'd1;
    end else begin
      y = y + 3'd1;
    end
    return {x, y};
  endfunction

  // Only one coordinate is ever skipped, so two chained steps always land on a valid node.
  assign nxt1 = rrNext(cur);
  assign nxt2 = (nxt1 == routerID) ? rrNext(nxt1) : nxt1;

  // The scan position advances once per granted packet.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= START;
    end else if (accept) begin
      cur <= nxt2;
    end
  end

  assign dest = cur;

`endif

  assign valid = destValid(dest, routerID, MESH_SIZE);

endmodule

// File: rtl/packet_injector.sv
// packet_injector: traffic source beside one mesh router.
// Builds packet words and offers them to the router's local input port with the
// Req/Gnt/Full handshake. A programmable gap separates packets, and an optional
// budget stops injection. Destination selection lives in dest_gen. Defining
// INJ_LFSR_EN there switches the generator from round-robin to LFSR.
module packet_injector
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID    = 6'b001_010,
  parameter int         MESH_SIZE   = 3,
  parameter int         packetwidth = 26,
  parameter int         INJ_GAP     = 4,
  parameter int         NUM_PACKETS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  packet_injector_if.master  bus,
  output logic               done,
  output logic [15:0]        sent_cnt
);

  localparam int GAP_W = (INJ_GAP > 0) ? $clog2(INJ_GAP + 1) : 1;

  logic [0:0]             state;
  logic [GAP_W-1:0]       gapCnt;
  logic [9:0]             packetId;
  logic [5:0]             dest;
  logic                   destOk;
  logic                   launch;
  logic                   grant;
  logic [15:0]            nextCnt;
  logic [packetwidth-1:0] packetWord;

  dest_gen #(
    .routerID  (routerID),
    .MESH_SIZE (MESH_SIZE)
  ) destGen (
    .clk   (clk),
    .reset (reset),
    .step  (bus.GntDnStr),
    .hold  (state == REQ),
    .dest  (dest),
    .valid (destOk)
  );

  assign grant   = (state == REQ) && bus.GntDnStr;
  assign launch  = (state == GAP) && (gapCnt == '0) && en && !done
                   && !bus.DnStrFull && destOk;
  assign nextCnt = (sent_cnt == 16'hFFFF) ? sent_cnt : sent_cnt + 16'd1;

  // Assemble the candidate packet word from the current ID and destination.
  always_comb begin
    packetWord                  = '0;
    packetWord[PID_MSB:PID_LSB] = packetId;
    packetWord[SID_MSB:SID_LSB] = routerID;
    packetWord[DST_MSB:DST_LSB] = dest;
    packetWord[2:0]             = packetId[2:0];
  end

  // GAP/REQ sequencing. The packet and the request are frozen while waiting for the router's grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= GAP;
      gapCnt        <= '0;
      packetId      <= '0;
      sent_cnt      <= '0;
      done          <= 1'b0;
      bus.ReqDnStr  <= 1'b0;
      bus.PacketOut <= '0;
    end else begin
      case (state)
        GAP: begin
          if (gapCnt != '0) begin
            gapCnt <= gapCnt - GAP_W'(1);
          end
          if (launch) begin
            bus.PacketOut <= packetWord;
            bus.ReqDnStr  <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (grant) begin
            bus.ReqDnStr <= 1'b0;
            packetId     <= packetId + 10'd1;
            sent_cnt     <= nextCnt;
            gapCnt       <= GAP_W'(INJ_GAP);
            state        <= GAP;
            if ((NUM_PACKETS != 0) && (nextCnt == 16'(NUM_PACKETS))) begin
              done <= 1'b1;
            end
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule
